rr_burst_arbiter: RTL
=====================

Name: rr_burst_arbiter

Overview:
- Round-robin arbiter with burst locking. It shares one downstream resource (bus port, memory channel) between N requesters.
- A grant is held for a whole multi-beat burst. It is released at the requester's last beat, at a programmable beat limit, or when the requester abandons.
- Priority then rotates to the requester after the one just served. Consecutive bursts run back-to-back with no idle cycle.

Parameters:
- N, 8: number of requesters; must be ≥ 2.
- MAX_BURST, 16: maximum beats per grant before forced release; must be ≥ 1.
- IDW, $clog2(N): width of the grant index.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: asynchronous reset, active-high.
- req, input, N: per-requester request. It must stay high while the requester has beats to send.
- last, input, N: per-requester last-beat flag. It is sampled only for the granted requester.
- res_ready, input, 1: the shared resource can accept a beat this cycle.
- gnt, output, N: registered one-hot grant; all zeros when idle.
- gnt_valid, output, 1: equals |gnt.
- gnt_id, output, IDW: binary index of the granted requester; holds its last value when idle.
- beat_fire, output, 1: combinational; equals gnt_valid & req[gnt_id] & res_ready.
- release_forced, output, 1: registered one-cycle pulse when a grant is released by the MAX_BURST limit.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - gnt=0, gnt_valid=0, gnt_id=0, release_forced=0.
  - State=IDLE, beat_cnt=0.
  - Priority pointer ptr=0, so requester 0 has highest priority and requester N-1 the lowest.
- Arbitration function: select the first set bit of req, scanning from index ptr upward and wrapping modulo N. Use the masked/unmasked two-arbiter structure or an equivalent.
- State IDLE:
  - If |req, next cycle gnt = one-hot of the winner, gnt_id = winner, state=BUSY, beat_cnt=0.
  - Request-to-grant latency is 1 cycle.
  - If req=0, remain in IDLE with gnt=0.
- State BUSY: gnt is stable; beat_cnt counts beat_fire events (width $clog2(MAX_BURST+1)).
- Release conditions, evaluated in the same cycle:
  - (a) beat_fire & last[gnt_id]: normal end of burst.
  - (b) beat_fire & beat_cnt == MAX_BURST-1: forced release; release_forced=1 next cycle.
  - (c) !req[gnt_id]: abandon. No beat is transferred that cycle.
  - If (a) and (b) hold together, treat it as a normal release (a); release_forced stays 0.
- On release:
  - ptr := (gnt_id+1) mod N.
  - Arbitrate the current-cycle req using the new ptr. The departing requester is therefore lowest priority, but is re-granted if it is the only requester.
  - If a winner exists, next cycle gnt = new winner, beat_cnt=0, state remains BUSY. There is no bubble.
  - Otherwise gnt=0 and state=IDLE.
- Without a release, gnt, gnt_id and ptr hold. res_ready low stalls the burst indefinitely; there is no timeout.
- last[] of non-granted requesters is ignored. req changes on non-granted requesters never affect the current grant.
- gnt is always one-hot or zero. It never changes while BUSY except at a release.
- Reset mid-burst: gnt drops asynchronously and ptr returns to 0. An in-flight burst is abandoned with no completion signalling.

Test Plan (N=4, MAX_BURST=4 unless stated):
- Reset, then req=4'b0100 with last set on the 2nd beat and res_ready=1.
  - Required: gnt=0100 one cycle after req; gnt_id=2; two beat_fire pulses.
  - Required: gnt=0 on the cycle after the last beat; ptr=3.
- req=4'b1111 held continuously, every beat marked last, res_ready=1.
  - Required: grant order 0,1,2,3,0 with one beat each and no idle cycle between grants.
- req=4'b0010, last never asserted, res_ready=1.
  - Required: exactly 4 beats, then release_forced=1 for one cycle.
  - Required: requester 1 is re-granted on the next cycle with beat_cnt=0.
- Requester 0 granted, res_ready=0 for 10 cycles, req[3] asserted meanwhile.
  - Required: gnt stays 0001 with no beat_fire.
  - Then res_ready=1 with last: gnt moves to 1000 on the following cycle.
- Requester 2 granted, req[2] deasserted before any beat, req[0]=1.
  - Required: next cycle gnt=0001 (ptr was 3, wraps to 0); release_forced=0.
- Assert rst mid-burst with gnt=0100.
  - Required: gnt=0 and gnt_valid=0 in the same cycle, before any clock edge.
  - After rst is released with req=4'b0110: gnt=0010.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//   Round-robin arbiter with burst locking. One shared downstream resource is
//   handed to one of N requesters at a time. A grant is held for the whole
//   burst and is released on the last beat, when the beat limit is reached,
//   or when the requester drops its request. Priority then rotates to the
//   requester after the one just served. Back-to-back bursts run with no
//   idle cycle.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active-high
//   req[N]         : per-requester request, held high while beats remain
//   last[N]        : per-requester last-beat flag (only the granted one is used)
//   res_ready      : shared resource accepts a beat this cycle
//   gnt[N]         : registered one-hot grant, zero when idle
//   gnt_valid      : registered, equals |gnt
//   gnt_id[IDW]    : registered index of the granted requester, holds when idle
//   beat_fire      : combinational, a beat transfers this cycle
//   release_forced : registered one-cycle pulse on a beat-limit release
// -----------------------------------------------------------------------------
module rr_burst_arbiter #(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned IDW       = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic           res_ready,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           beat_fire,
    output logic           release_forced
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] ID_MAX    = IDW'(N - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e         state_q,     state_d;
    logic [N-1:0]   gnt_q,       gnt_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0] gnt_id_q,    gnt_id_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic           forced_q,    forced_d;

    logic           fire_c;
    logic           fire_last_c;
    logic           fire_limit_c;
    logic           abandon_c;
    logic           release_c;
    logic [IDW-1:0] next_ptr_c;
    logic [IDW-1:0] arb_ptr_c;

    logic           arb_found_c;
    logic [IDW-1:0] arb_idx_c;
    logic           masked_any_c;
    logic [IDW-1:0] masked_idx_c;
    logic [IDW-1:0] unmasked_idx_c;

    assign gnt            = gnt_q;
    assign gnt_valid      = gnt_valid_q;
    assign gnt_id         = gnt_id_q;
    assign release_forced = forced_q;

    // A beat moves only while a grant is live, its owner requests and the resource is ready.
    assign fire_c    = gnt_valid_q & req[gnt_id_q] & res_ready;
    assign beat_fire = fire_c;

    // Release detection for the current burst.
    always_comb begin
        fire_last_c  = fire_c & last[gnt_id_q];
        fire_limit_c = fire_c & (cnt_q == CNT_LIMIT);
        abandon_c    = ~req[gnt_id_q];
        release_c    = (state_q == ST_BUSY) & (fire_last_c | fire_limit_c | abandon_c);
        next_ptr_c   = (gnt_id_q == ID_MAX) ? '0 : gnt_id_q + IDW'(1);
        // On a release the rotated pointer is used in the same cycle, so no bubble.
        arb_ptr_c    = release_c ? next_ptr_c : ptr_q;
    end

    // Two-arbiter round robin: lowest set bit at or above the pointer (masked),
    // falling back to the lowest set bit overall (unmasked) to wrap around.
    always_comb begin
        masked_any_c   = 1'b0;
        masked_idx_c   = '0;
        unmasked_idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                unmasked_idx_c = IDW'(i);
                if (i >= int'(arb_ptr_c)) begin
                    masked_any_c = 1'b1;
                    masked_idx_c = IDW'(i);
                end
            end
        end
        arb_found_c = |req;
        arb_idx_c   = masked_any_c ? masked_idx_c : unmasked_idx_c;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        forced_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found_c) begin
                    state_d     = ST_BUSY;
                    gnt_d       = N'(1) << arb_idx_c;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = arb_idx_c;
                    cnt_d       = '0;
                end
            end
            ST_BUSY: begin
                if (release_c) begin
                    ptr_d = next_ptr_c;
                    // A last beat landing on the limit counts as a normal release.
                    forced_d = fire_limit_c & ~fire_last_c;
                    cnt_d    = '0;
                    if (arb_found_c) begin
                        gnt_d       = N'(1) << arb_idx_c;
                        gnt_valid_d = 1'b1;
                        gnt_id_d    = arb_idx_c;
                    end else begin
                        state_d     = ST_IDLE;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (fire_c) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            forced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            forced_q    <= forced_d;
        end
    end

endmodule
